// File: rtl/tl_sram_responder_if.sv
// TileLink-UL A/D channel bundle between the access-stage master and the SRAM responder.
// The master drives the A channel and d_ready. The slave drives a_ready and the D channel.
interface tl_sram_responder_if #(
    parameter int SRC_W = 4
);
    logic             a_valid;
    logic             a_ready;
    logic [2:0]       a_opcode;
    logic [2:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [63:0]      a_address;
    logic [7:0]       a_mask;
    logic [63:0]      a_data;
    logic             d_valid;
    logic             d_ready;
    logic [2:0]       d_opcode;
    logic [2:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic             d_denied;
    logic [63:0]      d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
    );
endinterface

// File: rtl/tl_sram_responder.sv
// TileLink-UL SRAM responder with one transaction outstanding; d_valid rises LATENCY+1 cycles after accept.
// a_ready is high only in IDLE. The response is held with stable fields until d_ready.
module tl_sram_responder #(
    parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter int          SRC_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    tl_sram_responder_if.slave tl
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             d_valid_q, d_valid_d;
    logic [2:0]       d_opcode_q, d_opcode_d;
    logic [2:0]       d_size_q, d_size_d;
    logic [SRC_W-1:0] d_source_q, d_source_d;
    logic             d_denied_q, d_denied_d;
    logic [63:0]      d_data_q, d_data_d;

    logic [63:0]      mem [DEPTH_WORDS];

    logic [63:0]      off;
    logic [IW-1:0]    a_idx;
    logic [IW-1:0]    rd_idx;
    logic             in_range, aligned, op_ok, is_get, denied;
    logic             accept, wr_en, enter_resp, rd_go;
    logic             unused_off_lsb;

    // Range check relies on DEPTH_WORDS being a power of two: any bit above the index field means overflow.
    assign off            = tl.a_address - ADDR_BASE;
    assign a_idx          = off[IW+2:3];
    assign unused_off_lsb = ^off[2:0];
    assign in_range       = (tl.a_address >= ADDR_BASE) && (off[63:IW+3] == '0);
    assign op_ok          = (tl.a_opcode == 3'd0) || (tl.a_opcode == 3'd1) || (tl.a_opcode == 3'd4);
    assign is_get         = (tl.a_opcode == 3'd4);

    always_comb begin
        case (tl.a_size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~tl.a_address[0];
            3'd2:    aligned = (tl.a_address[1:0] == 2'b00);
            3'd3:    aligned = (tl.a_address[2:0] == 3'b000);
            default: aligned = 1'b0;
        endcase
    end

    assign denied = ~in_range | ~aligned | ~op_ok;
    assign accept = tl.a_valid & (state_q == IDLE);
    assign wr_en  = accept & ~denied & ~is_get;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_denied_d = d_denied_q;
        d_data_d   = d_data_q;
        enter_resp = 1'b0;
        rd_go      = 1'b0;
        rd_idx     = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d      = a_idx;
                    d_opcode_d = {2'b00, is_get};
                    d_size_d   = tl.a_size;
                    d_source_d = tl.a_source;
                    d_denied_d = denied;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                        rd_go      = is_get & ~denied;
                        rd_idx     = a_idx;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                    rd_go      = d_opcode_q[0] & ~d_denied_q;
                end
            end
            RESP: begin
                if (tl.d_ready) begin
                    state_d   = IDLE;
                    d_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Read data is captured on the edge into RESP so it reflects any write completed before it.
        if (enter_resp) begin
            d_valid_d = 1'b1;
            d_data_d  = rd_go ? mem[rd_idx] : 64'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_denied_q <= 1'b0;
            d_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_denied_q <= d_denied_d;
            d_data_q   <= d_data_d;
        end
    end

    // Storage is deliberately not reset; writes commit on the accept edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (tl.a_mask[i]) mem[a_idx][8*i +: 8] <= tl.a_data[8*i +: 8];
            end
        end
    end

    assign tl.a_ready  = (state_q == IDLE);
    assign tl.d_valid  = d_valid_q;
    assign tl.d_opcode = d_opcode_q;
    assign tl.d_size   = d_size_q;
    assign tl.d_source = d_source_q;
    assign tl.d_denied = d_denied_q;
    assign tl.d_data   = d_data_q;
endmodule

// File: tb/tb_tl_sram_responder.sv
// Bench for tl_sram_responder: three instances (LATENCY 0, 1, 3) share one request stream
// and are checked cycle by cycle against a word-array model of the memory and response timing.
module tb_tl_sram_responder;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 1 : 3;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid;
    logic [2:0]  a_opcode, a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address, a_data;
    logic [7:0]  a_mask;
    logic        d_ready;

    logic        dv [3];
    logic        ar [3];
    logic [2:0]  dop [3];
    logic [2:0]  dsz [3];
    logic [3:0]  dsrc [3];
    logic        dden [3];
    logic [63:0] ddat [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tl_sram_responder_if #(.SRC_W(4)) bus ();
        assign bus.a_valid   = a_valid;
        assign bus.a_opcode  = a_opcode;
        assign bus.a_size    = a_size;
        assign bus.a_source  = a_source;
        assign bus.a_address = a_address;
        assign bus.a_mask    = a_mask;
        assign bus.a_data    = a_data;
        assign bus.d_ready   = d_ready;
        tl_sram_responder #(
            .ADDR_BASE  (BASE),
            .DEPTH_WORDS(1024),
            .LATENCY    (lat_of(g)),
            .SRC_W      (4)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .tl   (bus)
        );
        assign dv[g]   = bus.d_valid;
        assign ar[g]   = bus.a_ready;
        assign dop[g]  = bus.d_opcode;
        assign dsz[g]  = bus.d_size;
        assign dsrc[g] = bus.d_source;
        assign dden[g] = bus.d_denied;
        assign ddat[g] = bus.d_data;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] mdl [1024];
    bit          known [1024];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request, then a per-cycle comparison of every instance against the expected timeline.
    task automatic run_txn(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                           input logic [63:0] addr, input logic [7:0] msk, input logic [63:0] dat,
                           input int rdy_k);
        logic [63:0] off, exp_data;
        logic        den, in_rng, algn, chk_data;
        int          idx;
        off      = addr - BASE;
        in_rng   = (addr >= BASE) && ((off >> 3) < 64'd1024);
        algn     = (sz <= 3'd3) && ((addr % (64'd1 << sz)) == 64'd0);
        den      = !in_rng || !algn || !(op == 3'd0 || op == 3'd1 || op == 3'd4);
        idx      = in_rng ? int'(off >> 3) : 0;
        exp_data = 64'd0;
        chk_data = 1'b1;
        if (!den && op == 3'd4) begin
            exp_data = mdl[idx];
            chk_data = known[idx];
        end
        if (!den && op != 3'd4) begin
            for (int i = 0; i < 8; i++) if (msk[i]) mdl[idx][8*i +: 8] = dat[8*i +: 8];
            if (msk == 8'hFF) known[idx] = 1'b1;
        end
        @(negedge clk);
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = msk;
        a_data    = dat;
        a_valid   = 1'b1;
        d_ready   = (rdy_k == 0);
        for (int k = 1; k <= rdy_k + 6; k++) begin
            @(negedge clk);
            if (k == 1) a_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
                int first, done;
                first = 1 + lat_of(g);
                done  = ((first > rdy_k) ? first : rdy_k) + 1;
                if (k < first || k >= done) begin
                    check_eq($sformatf("L%0d_dvalid_lo_k%0d", lat_of(g), k), dv[g], 0);
                    check_eq($sformatf("L%0d_aready_k%0d", lat_of(g), k), ar[g], (k >= done));
                end else begin
                    check_eq($sformatf("L%0d_dvalid_hi_k%0d", lat_of(g), k), dv[g], 1);
                    check_eq($sformatf("L%0d_aready_busy_k%0d", lat_of(g), k), ar[g], 0);
                    check_eq($sformatf("L%0d_dopcode", lat_of(g)), dop[g], (op == 3'd4));
                    check_eq($sformatf("L%0d_ddenied", lat_of(g)), dden[g], den);
                    check_eq($sformatf("L%0d_dsize", lat_of(g)), dsz[g], sz);
                    check_eq($sformatf("L%0d_dsource", lat_of(g)), dsrc[g], src);
                    if (chk_data) check_eq($sformatf("L%0d_ddata_a%h", lat_of(g), addr), ddat[g], exp_data);
                end
            end
            if (k >= rdy_k) d_ready = 1'b1;
        end
        d_ready = 1'b0;
    endtask

    initial begin
        logic [2:0]  op, sz;
        logic [63:0] addr, wdat;
        int          r, idx, boff, rk;
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_size    = 3'd0;
        a_source  = 4'd0;
        a_address = 64'd0;
        a_mask    = 8'd0;
        a_data    = 64'd0;
        d_ready   = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mdl[i]   = 64'd0;
            known[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("L%0d_rst_dvalid", lat_of(g)), dv[g], 0);
            check_eq($sformatf("L%0d_rst_aready", lat_of(g)), ar[g], 1);
            check_eq($sformatf("L%0d_rst_dfields", lat_of(g)), {dop[g], dsz[g], dsrc[g], dden[g]}, 0);
            check_eq($sformatf("L%0d_rst_ddata", lat_of(g)), ddat[g], 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_txn(3'd0, 3'd3, 4'd1, BASE + 64'(i) * 8, 8'hFF, {$urandom, $urandom}, 0);
        run_txn(3'd0, 3'd3, 4'd1, BASE + 64'd1023 * 8, 8'hFF, {$urandom, $urandom}, 0);

        run_txn(3'd0, 3'd3, 4'd3, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 0);
        run_txn(3'd4, 3'd3, 4'd5, 64'h8000_0010, 8'h00, 64'd0, 0);
        run_txn(3'd1, 3'd3, 4'd6, 64'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 0);
        run_txn(3'd4, 3'd3, 4'd7, 64'h8000_0010, 8'h00, 64'd0, 0);
        check_eq("partial_model", mdl[2], 64'h11223344_BBBBBBBB);
        run_txn(3'd4, 3'd3, 4'd2, 64'h8000_2000, 8'h00, 64'd0, 0);
        run_txn(3'd4, 3'd3, 4'd2, 64'h7FFF_FFF8, 8'h00, 64'd0, 0);
        run_txn(3'd0, 3'd3, 4'd2, 64'h8000_2000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0);
        run_txn(3'd0, 3'd3, 4'd2, 64'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0);
        run_txn(3'd4, 3'd3, 4'd2, BASE, 8'h00, 64'd0, 0);
        run_txn(3'd4, 3'd3, 4'd2, BASE + 64'd1023 * 8, 8'h00, 64'd0, 0);
        run_txn(3'd4, 3'd2, 4'd9, 64'h8000_0002, 8'h00, 64'd0, 0);
        run_txn(3'd6, 3'd3, 4'd9, 64'h8000_0008, 8'hFF, 64'd0, 0);
        run_txn(3'd4, 3'd3, 4'd4, 64'h8000_0010, 8'h00, 64'd0, 9);

        // Reset pulsed while the LATENCY 1 and 3 instances are still waiting.
        wdat = 64'hCAFE_F00D_0123_4567;
        @(negedge clk);
        a_opcode  = 3'd0;
        a_size    = 3'd3;
        a_source  = 4'd8;
        a_address = BASE + 64'd7 * 8;
        a_mask    = 8'hFF;
        a_data    = wdat;
        a_valid   = 1'b1;
        d_ready   = 1'b0;
        @(negedge clk);
        a_valid = 1'b0;
        rst_n   = 1'b0;
        mdl[7]  = wdat;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                check_eq($sformatf("L%0d_midrst_dvalid_k%0d", lat_of(g), k), dv[g], 0);
                check_eq($sformatf("L%0d_midrst_aready_k%0d", lat_of(g), k), ar[g], 1);
            end
        end
        run_txn(3'd4, 3'd3, 4'd8, BASE + 64'd7 * 8, 8'h00, 64'd0, 0);

        for (int n = 0; n < 70; n++) begin
            r  = $urandom_range(0, 9);
            op = (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : (r < 9) ? 3'd4 : 3'($urandom_range(0, 7));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            idx  = $urandom_range(0, 15);
            boff = $urandom_range(0, 7);
            if ($urandom_range(0, 7) != 0) boff = boff & ~((1 << sz) - 1);
            addr = BASE + 64'(idx) * 8 + 64'(boff);
            r = $urandom_range(0, 19);
            if (r == 0) addr = BASE + 64'($urandom_range(1024, 1100)) * 8;
            if (r == 1) addr = BASE - 64'($urandom_range(1, 4)) * 8;
            rk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            run_txn(op, sz, 4'($urandom_range(0, 15)), addr, 8'($urandom_range(0, 255)),
                    {$urandom, $urandom}, rk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
